// File: rtl/z1010_ff_slice.sv
// -----------------------------------------------------------------------------
// z1010_ff_slice
//
// Configurable flip-flop slice for a z1010 fabric logic block. A 4N-bit shadow
// chain is loaded serially. A commit copies the shadow into the active
// configuration. Each user flop then behaves as the primitive that its 4-bit
// field {use_e, mode[2:0]} selects:
//   000 dff   : q <= d
//   001 dffr  : ctl_n low clears q asynchronously
//   010 dffs  : ctl_n low sets q asynchronously
//   011 dffl  : ctl_n low clears q at the clock edge
//   100 dffh  : ctl_n low sets q at the clock edge
//   101..111  : reserved. These decode as dff and raise the sticky cfg_err.
// use_e=1 gates only the data load (e low holds q). Sync and async controls
// are not gated by the enable.
//
// Optional feature:
//   Z1010_FF_CFG_READBACK_EN - when defined, cfg_out = shadow MSB, so the chain
//                              can be daisy-chained and read back. When
//                              undefined, cfg_out is tied low.
//
// Ports:
//   clk        fabric clock, rising edge
//   nreset     asynchronous active-low reset
//   cfg_shift  shift the shadow chain by one bit
//   cfg_in     serial config data, enters shadow bit 0
//   cfg_commit single-cycle pulse: shadow -> active, clear all q
//   cfg_out    serial chain output
//   cfg_valid  high once a commit has occurred since reset
//   cfg_err    sticky: a reserved mode code was committed
//   d, e, ctl_n per-flop data, enable (active-high) and control (active-low)
//   q          flop outputs
// -----------------------------------------------------------------------------
module z1010_ff_slice #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         cfg_shift,
    input  logic         cfg_in,
    input  logic         cfg_commit,
    output logic         cfg_out,
    output logic         cfg_valid,
    output logic         cfg_err,
    input  logic [N-1:0] d,
    input  logic [N-1:0] e,
    input  logic [N-1:0] ctl_n,
    output logic [N-1:0] q
);

    typedef enum logic {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_reg;
    logic [4*N-1:0]   shadow_reg;
    logic [4*N-1:0]   active_reg;
    logic             cfg_valid_reg;
    logic             cfg_err_reg;
    logic [N-1:0]     reserved_in_shadow;
    logic             run;

    assign run = (state_reg == ST_RUN);

    // Reserved codes are detected on the shadow, so the error flag is set at
    // the same edge on which the offending field becomes active.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rsv
            assign reserved_in_shadow[gi] = (shadow_reg[4*gi+2 -: 3] > 3'd4);
        end
    endgenerate

    // Configuration-side control. A commit takes priority over a shift in the
    // same cycle, so the shadow that was committed remains intact.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg     <= ST_UNCFG;
            shadow_reg    <= '0;
            active_reg    <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else if (cfg_commit) begin
            state_reg     <= ST_RUN;
            active_reg    <= shadow_reg;
            cfg_valid_reg <= 1'b1;
            if (|reserved_in_shadow) begin
                cfg_err_reg <= 1'b1;
            end
        end else if (cfg_shift) begin
            shadow_reg <= {shadow_reg[4*N-2:0], cfg_in};
        end
    end

    assign cfg_valid = cfg_valid_reg;
    assign cfg_err   = cfg_err_reg;

`ifdef Z1010_FF_CFG_READBACK_EN
    assign cfg_out = shadow_reg[4*N-1];
`else
    assign cfg_out = 1'b0;
`endif

    // Per-flop datapath
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ff
            logic [2:0] mode_raw;
            logic [2:0] mode;
            logic       use_e;
            logic       c;
            logic       async_clr;
            logic       async_set;
            logic       sync_clr;
            logic       sync_set;
            logic       q_bit_reg;
            logic       q_bit_next;

            assign mode_raw = active_reg[4*gi+2 -: 3];
            assign use_e    = active_reg[4*gi+3];
            assign mode     = (mode_raw > 3'd4) ? 3'd0 : mode_raw;
            assign c        = ctl_n[gi];

            // Async controls act only in RUN, so ctl_n has no effect on an
            // unconfigured slice.
            assign async_clr = run && (mode == 3'd1) && !c;
            assign async_set = run && (mode == 3'd2) && !c;
            assign sync_clr  = (mode == 3'd3) && !c;
            assign sync_set  = (mode == 3'd4) && !c;

            always_comb begin
                q_bit_next = d[gi];
                if (sync_clr) begin
                    q_bit_next = 1'b0;
                end else if (sync_set) begin
                    q_bit_next = 1'b1;
                end else if (use_e && !e[gi]) begin
                    q_bit_next = q_bit_reg;
                end
            end

            // The async control is level-sensitive through the clock branch.
            // While ctl_n is held low, every edge reloads the forced value. The
            // flop therefore stays forced until the first edge after ctl_n
            // rises.
            always_ff @(posedge clk or negedge nreset or posedge async_clr or posedge async_set) begin
                if (!nreset) begin
                    q_bit_reg <= 1'b0;
                end else if (async_clr) begin
                    q_bit_reg <= 1'b0;
                end else if (async_set) begin
                    q_bit_reg <= 1'b1;
                end else if (cfg_commit) begin
                    q_bit_reg <= 1'b0;
                end else if (run) begin
                    q_bit_reg <= q_bit_next;
                end
            end

            assign q[gi] = q_bit_reg;
        end
    endgenerate

endmodule
